// File: rtl/miriscv_data_mem_resp.sv
// ---------------------------------------------------------------------------
// miriscv_data_mem_resp
// Memory-side responder for the core's data-memory request protocol. Holds a
// word-organised RAM with byte-lane writes and answers every accepted request
// with a single-cycle ready pulse LATENCY cycles after the request is captured.
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   arstn_i       synchronous active-low reset
//   data_req_i    request valid, held by the initiator until ready is seen
//   data_we_i     1 = write, 0 = read
//   data_be_i     byte enables for writes, bit n selects wdata[8n+7:8n]
//   data_addr_i   byte address, bits [1:0] ignored
//   data_wdata_i  lane-replicated write data
//   data_rdata_o  full read word, held until the next response
//   mem_ready_o   one-cycle response pulse
//   data_err_o    address outside the array, valid with mem_ready_o
// ---------------------------------------------------------------------------
module miriscv_data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        mem_ready_o,
  output logic        data_err_o
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              capture;
  logic              access;

  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  word_idx;

  logic [31:0]       mem [DEPTH_WORDS];

  // Decode works on the captured address only; the subtraction wraps so
  // addresses below BASE_ADDR land far out of range.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (offset < SPAN_BYTES);
  assign word_idx = offset[IDX_W+1:2];

  // The counter holds the number of WAIT cycles still to spend. Capture
  // always goes through WAIT so that the array access and the ready pulse
  // land exactly LATENCY edges after the capture edge, including LATENCY=1
  // where the counter is loaded with zero and WAIT lasts a single cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          capture = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // A request still held high here is the one just answered.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request fields are latched once; WAIT and RESP never look at the inputs.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      we_q    <= data_we_i;
      be_q    <= data_be_i;
      addr_q  <= data_addr_i;
      wdata_q <= data_wdata_i;
    end
  end

  // RAM contents survive reset, but a reset on the access edge must still
  // suppress the write so an aborted transaction leaves no trace.
  always_ff @(posedge clk_i) begin
    if (arstn_i && access && we_q && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (be_q[n]) begin
          mem[word_idx][8*n +: 8] <= wdata_q[8*n +: 8];
        end
      end
    end
  end

  // State, counter and the registered response outputs.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      mem_ready_o  <= 1'b0;
      data_err_o   <= 1'b0;
      data_rdata_o <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_ready_o <= access;
      data_err_o  <= access && !in_range;
      if (access) begin
        if (!in_range) begin
          data_rdata_o <= 32'd0;
        end else if (!we_q) begin
          data_rdata_o <= mem[word_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_miriscv_data_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_miriscv_data_mem_resp
// Self-checking bench for miriscv_data_mem_resp. Two instances are exercised:
// instance A (1024 words, LATENCY=2, base 0) and instance B (64 words,
// LATENCY=1, base 0x1000). A behavioural model keeps a small window of each
// array plus the expected held read word and predicts latency, error flag
// and read data for directed and randomized transactions.
// ---------------------------------------------------------------------------
module tb_miriscv_data_mem_resp;

  localparam int unsigned A_DEPTH = 1024;
  localparam int unsigned A_LAT   = 2;
  localparam logic [31:0] A_BASE  = 32'h0000_0000;
  localparam int unsigned B_DEPTH = 64;
  localparam int unsigned B_LAT   = 1;
  localparam logic [31:0] B_BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        arstn;
  logic        req_a, req_b;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b;
  logic        err_a, err_b;

  int numCompared;
  int numMismatched;

  logic [31:0] memModel [2][16];
  logic [31:0] expRdata [2];
  logic [31:0] baseOf   [2];
  logic [31:0] spanOf   [2];
  logic [31:0] latOf    [2];

  int pulses, gap, cycles, extra, seenCnt;

  always #5 clk = ~clk;

  miriscv_data_mem_resp #(
    .DEPTH_WORDS (A_DEPTH),
    .LATENCY     (A_LAT),
    .BASE_ADDR   (A_BASE)
  ) dut_a (
    .clk_i        (clk),
    .arstn_i      (arstn),
    .data_req_i   (req_a),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_addr_i  (addr),
    .data_wdata_i (wdata),
    .data_rdata_o (rdata_a),
    .mem_ready_o  (ready_a),
    .data_err_o   (err_a)
  );

  miriscv_data_mem_resp #(
    .DEPTH_WORDS (B_DEPTH),
    .LATENCY     (B_LAT),
    .BASE_ADDR   (B_BASE)
  ) dut_b (
    .clk_i        (clk),
    .arstn_i      (arstn),
    .data_req_i   (req_b),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_addr_i  (addr),
    .data_wdata_i (wdata),
    .data_rdata_o (rdata_b),
    .mem_ready_o  (ready_b),
    .data_err_o   (err_b)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic setReq(input int inst, input logic v);
    if (inst == 0) req_a = v;
    else           req_b = v;
  endtask

  function automatic logic getReady(input int inst);
    return (inst == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic getErr(input int inst);
    return (inst == 0) ? err_a : err_b;
  endfunction

  function automatic logic [31:0] getRdata(input int inst);
    return (inst == 0) ? rdata_a : rdata_b;
  endfunction

  // Reference behaviour: range test on the wrapped offset, byte-lane merge
  // on writes, read word or zero on the held read data.
  task automatic modelAccess(input int inst, input logic w, input logic [3:0] b,
                             input logic [31:0] a, input logic [31:0] d, output logic expErr);
    logic [31:0] off;
    int          word;
    off = a - baseOf[inst];
    if (off >= spanOf[inst]) begin
      expErr         = 1'b1;
      expRdata[inst] = 32'd0;
    end else begin
      expErr = 1'b0;
      word   = int'(off >> 2);
      if (w) begin
        for (int n = 0; n < 4; n++) begin
          if (b[n]) memModel[inst][word][8*n +: 8] = d[8*n +: 8];
        end
      end else begin
        expRdata[inst] = memModel[inst][word];
      end
    end
  endtask

  // One complete transaction: drive, wait (bounded) for ready, check the
  // response and that the pulse is exactly one cycle wide.
  task automatic applyStimulus(input int inst, input logic w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d);
    logic expErr;
    int   waited;
    logic seen;
    modelAccess(inst, w, b, a, d, expErr);
    @(negedge clk);
    we    = w;
    be    = b;
    addr  = a;
    wdata = d;
    setReq(inst, 1'b1);
    @(posedge clk);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 40) begin
      @(negedge clk);
      if (getReady(inst)) seen = 1'b1;
      else                waited++;
    end
    setReq(inst, 1'b0);
    checkOutput("latency", 32'(waited), latOf[inst]);
    checkOutput("err", 32'(getErr(inst)), 32'(expErr));
    checkOutput("rdata", getRdata(inst), expRdata[inst]);
    @(negedge clk);
    checkOutput("pulse_ready", 32'(getReady(inst)), 32'd0);
    checkOutput("pulse_err", 32'(getErr(inst)), 32'd0);
  endtask

  function automatic logic [31:0] randomAddr(input int inst);
    int unsigned sel;
    if ($urandom_range(0, 5) != 0) begin
      return baseOf[inst] + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    end
    sel = $urandom_range(0, 2);
    if (sel == 0) return baseOf[inst] + spanOf[inst] + 32'(4 * $urandom_range(0, 15));
    if (sel == 1) return baseOf[inst] - 32'(4 * (1 + $urandom_range(0, 3)));
    return $urandom | 32'h8000_0000;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    baseOf[0] = A_BASE;  spanOf[0] = 32'(4 * A_DEPTH);  latOf[0] = 32'(A_LAT);
    baseOf[1] = B_BASE;  spanOf[1] = 32'(4 * B_DEPTH);  latOf[1] = 32'(B_LAT);
    expRdata[0] = 32'd0;
    expRdata[1] = 32'd0;
    arstn = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    we    = 1'b0;
    be    = 4'h0;
    addr  = 32'd0;
    wdata = 32'd0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready_a", 32'(ready_a), 32'd0);
    checkOutput("rst_err_a", 32'(err_a), 32'd0);
    checkOutput("rst_rdata_a", rdata_a, 32'd0);
    checkOutput("rst_ready_b", 32'(ready_b), 32'd0);
    checkOutput("rst_err_b", 32'(err_b), 32'd0);
    checkOutput("rst_rdata_b", rdata_b, 32'd0);
    arstn = 1'b1;

    // Prefill the modelled window of both arrays
    for (int inst = 0; inst < 2; inst++) begin
      for (int w = 0; w < 16; w++) begin
        applyStimulus(inst, 1'b1, 4'hF, baseOf[inst] + 32'(4 * w), $urandom);
      end
    end

    // Plain read of word 0 with LATENCY=2
    applyStimulus(0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Full word write, single byte-lane write, read back
    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b1, 4'b0100, 32'h12, 32'h00AA_0000);
    applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0);
    checkOutput("byte_merge", rdata_a, 32'hDEAA_BEEF);

    // Three reads with the request held high the whole time
    @(negedge clk);
    we     = 1'b0;
    be     = 4'h0;
    addr   = 32'h4;
    req_a  = 1'b1;
    pulses = 0;
    gap    = 0;
    cycles = 0;
    while (pulses < 3 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      gap++;
      if (ready_a) begin
        checkOutput("b2b_rdata", rdata_a, memModel[0][addr[5:2]]);
        checkOutput("b2b_err", 32'(err_a), 32'd0);
        checkOutput("b2b_gap", 32'(gap), (pulses == 0) ? 32'(A_LAT + 1) : 32'(A_LAT + 2));
        pulses++;
        gap = 0;
        if (pulses < 3) addr = addr + 32'd4;
        else            req_a = 1'b0;
      end
    end
    req_a = 1'b0;
    checkOutput("b2b_pulses", 32'(pulses), 32'd3);
    expRdata[0] = memModel[0][3];
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready_a) extra++;
    end
    checkOutput("b2b_extra", 32'(extra), 32'd0);

    // Out-of-range reads and writes; the writes alias word 0 if decoded wrongly
    applyStimulus(0, 1'b0, 4'h0, A_BASE + 32'(4 * A_DEPTH), 32'h0);
    applyStimulus(0, 1'b1, 4'hF, A_BASE + 32'(4 * A_DEPTH), $urandom);
    applyStimulus(0, 1'b0, 4'h0, A_BASE, 32'h0);
    applyStimulus(1, 1'b1, 4'hF, B_BASE + 32'(4 * B_DEPTH), $urandom);
    applyStimulus(1, 1'b0, 4'h0, B_BASE, 32'h0);
    applyStimulus(1, 1'b0, 4'h0, B_BASE - 32'd4, 32'h0);

    // Reset while a write is waiting aborts it
    @(negedge clk);
    we    = 1'b1;
    be    = 4'hF;
    addr  = 32'h20;
    wdata = 32'h1234_5678;
    req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arstn = 1'b0;
    req_a = 1'b0;
    seenCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready_a) seenCnt++;
      if (i == 1) arstn = 1'b1;
    end
    checkOutput("abort_noready", 32'(seenCnt), 32'd0);
    checkOutput("abort_rdata_a", rdata_a, 32'd0);
    checkOutput("abort_rdata_b", rdata_b, 32'd0);
    expRdata[0] = 32'd0;
    expRdata[1] = 32'd0;
    applyStimulus(0, 1'b0, 4'h0, 32'h20, 32'h0);

    // LATENCY=1 instance: read, empty-mask write, read back
    applyStimulus(1, 1'b0, 4'h0, B_BASE, 32'h0);
    applyStimulus(1, 1'b1, 4'h0, B_BASE + 32'd8, $urandom);
    applyStimulus(1, 1'b0, 4'h0, B_BASE + 32'd8, 32'h0);

    // Randomized traffic on both instances
    for (int t = 0; t < 120; t++) begin
      int inst;
      inst = int'($urandom_range(0, 1));
      applyStimulus(inst, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    randomAddr(inst), $urandom);
    end

    // Final sweep reads the whole window back
    for (int inst = 0; inst < 2; inst++) begin
      for (int w = 0; w < 16; w++) begin
        applyStimulus(inst, 1'b0, 4'h0, baseOf[inst] + 32'(4 * w), 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
